// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer in front of a single-port memory.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise p1 wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    state_t state_nx;
    logic   own;
    logic   lat_write;
    logic   gnt0;
    logic   gnt1;
    logic   hs;
    logic   sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // On a tie, the port that did not win last time goes next.
    assign gnt1 = p1_req_valid && (!p0_req_valid || !last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (hs) begin
            last_grant <= gnt1;
        end
    end
`else
    assign gnt1 = p1_req_valid;
`endif

    assign gnt0 = p0_req_valid && !gnt1;
    assign hs   = (state == IDLE) && !rst && (gnt0 || gnt1);

    assign p0_req_ready = hs && gnt0;
    assign p1_req_ready = hs && gnt1;

    assign sel_write = gnt1 ? p1_req_write : p0_req_write;
    assign sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
    assign sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (hs) state_nx = ISSUE;
            ISSUE:   state_nx = lat_write ? RESP : WAIT;
            WAIT:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes and response pulses default low so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            own          <= 1'b0;
            lat_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_rdata <= '0;
        end else begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            if (hs) begin
                own       <= gnt1;
                lat_write <= sel_write;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_read  <= !sel_write;
                mem_write <= sel_write;
            end else if (state == ISSUE && lat_write) begin
                if (own) begin
                    p1_rsp_valid <= 1'b1;
                    p1_rsp_rdata <= '0;
                end else begin
                    p0_rsp_valid <= 1'b1;
                    p0_rsp_rdata <= '0;
                end
            end else if (state == WAIT) begin
                if (own) begin
                    p1_rsp_valid <= 1'b1;
                    p1_rsp_rdata <= mem_data;
                end else begin
                    p0_rsp_valid <= 1'b1;
                    p0_rsp_rdata <= mem_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered memory model.
// Tie expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_req_write;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic        p0_rsp_valid;
    logic        p1_req_valid, p1_req_ready, p1_req_write;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic        p1_rsp_valid;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_data;

    logic [31:0] mem_model [0:4095];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rcnt = 0;
    int wcnt = 0;
    int hs_cyc = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_write(p0_req_write), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_write(p1_req_write), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_rdata(p1_rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mem_model[mem_addr[11:0]] <= mem_wdata;
        if (mem_read) mem_data <= mem_model[mem_addr[11:0]];
    end

    always @(negedge clk) begin
        if (mem_read) rcnt++;
        if (mem_write) wcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_req_write = wr;
            p0_req_addr = a; p0_req_wdata = d;
        end else begin
            p1_req_valid = 1'b1; p1_req_write = wr;
            p1_req_addr = a; p1_req_wdata = d;
        end
        #1;
    endtask

    task automatic xfer(input int port, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
        int n = 0;
        drive(port, wr, a, d);
        while (!(port == 0 ? p0_req_ready : p1_req_ready) && n < 20) begin
            step();
            n++;
        end
        chk("ready", port == 0 ? p0_req_ready : p1_req_ready, 1);
        hs_cyc = cyc;
        step();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        #1;
        chk("mem_read", mem_read, !wr);
        chk("mem_write", mem_write, wr);
        chk("mem_addr", mem_addr, a);
        if (wr) chk("mem_wdata", mem_wdata, d);
        chk("rdy_busy", {p0_req_ready, p1_req_ready}, 0);
        step();
        chk("strobe_off", {mem_read, mem_write}, 0);
        if (!wr) begin
            chk("rsp_early", {p0_rsp_valid, p1_rsp_valid}, 0);
            step();
        end
        chk("rsp_valid", {p1_rsp_valid, p0_rsp_valid}, port == 0 ? 1 : 2);
        chk("rsp_rdata", port == 0 ? p0_rsp_rdata : p1_rsp_rdata, exp);
        step();
        chk("rsp_end", {p0_rsp_valid, p1_rsp_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int prev;
        int exp_port;
        logic seen;
        for (int i = 0; i < 4096; i++) mem_model[i] = 32'hA000_0000 | i;
        mem_data = '0;
        rst = 1'b1;
        p0_req_valid = 0; p0_req_write = 0; p0_req_addr = 0; p0_req_wdata = 0;
        p1_req_valid = 0; p1_req_write = 0; p1_req_addr = 0; p1_req_wdata = 0;
        step();
        step();
        drive(0, 1'b0, 32'd16, 32'd0);
        chk("rst_ready", p0_req_ready, 0);
        p0_req_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rsp", {p0_rsp_valid, p1_rsp_valid}, 0);
        chk("rst_rdata0", p0_rsp_rdata, 0);
        chk("rst_rdata1", p1_rsp_rdata, 0);

        xfer(0, 1'b0, 32'd512, 32'd0, 32'hA000_0200);
        xfer(1, 1'b1, 32'd200, 32'hABC, 32'd0);
        xfer(0, 1'b0, 32'd200, 32'd0, 32'hABC);

        // Ties after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd4, 32'd0);
        k = 0;
        prev = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            chk("tie_both", p0_req_ready && p1_req_ready, 0);
            if (p0_req_ready || p1_req_ready) begin
`ifdef MEM_ARB_RR_EN
                exp_port = k % 2;
`else
                exp_port = 1;
`endif
                chk("tie_grant", p1_req_ready ? 1 : 0, exp_port);
                if (k > 0) chk("tie_gap", cyc - prev, 4);
                prev = cyc;
                k++;
            end
            step();
        end
        chk("tie_count", k, 6);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        repeat (4) step();

        // Reset lands in the WAIT cycle of a p0 read.
        drive(0, 1'b0, 32'd8, 32'd0);
        chk("mid_ready", p0_req_ready, 1);
        step();
        p0_req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_addr", mem_addr, 0);
        chk("mid_rdata", p0_rsp_rdata, 0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | p0_rsp_valid | p1_rsp_valid;
            step();
        end
        chk("mid_no_rsp", seen, 0);
        xfer(0, 1'b0, 32'd8, 32'd0, 32'hA000_0008);

        // p1 drops and reasserts while p0 is in flight.
        wcnt = 0;
        drive(0, 1'b0, 32'd4, 32'd0);
        chk("drop_p0_rdy", p0_req_ready, 1);
        step();
        p0_req_valid = 1'b0;
        drive(1, 1'b1, 32'd300, 32'h55);
        chk("drop_issue_rdy", p1_req_ready, 0);
        step();
        p1_req_valid = 1'b0;
        #1;
        chk("drop_wait_rdy", p1_req_ready, 0);
        step();
        drive(1, 1'b1, 32'd300, 32'h55);
        chk("drop_resp_rdy", p1_req_ready, 0);
        chk("drop_p0_rsp", p0_rsp_valid, 1);
        chk("drop_p0_data", p0_rsp_rdata, 32'hA000_0004);
        chk("drop_no_wr", wcnt, 0);
        step();
        chk("drop_idle_rdy", p1_req_ready, 1);
        step();
        p1_req_valid = 1'b0;
        chk("drop_wr", mem_write, 1);
        chk("drop_addr", mem_addr, 300);
        step();
        chk("drop_p1_rsp", p1_rsp_valid, 1);
        step();
        chk("drop_wcnt", wcnt, 1);
        chk("drop_mem", mem_model[300], 32'h55);

        // Back-to-back reads.
        rcnt = 0;
        xfer(0, 1'b0, 32'd0, 32'd0, 32'hA000_0000);
        prev = hs_cyc;
        xfer(0, 1'b0, 32'd4, 32'd0, 32'hA000_0004);
        chk("b2b_gap1", hs_cyc - prev, 4);
        prev = hs_cyc;
        xfer(0, 1'b0, 32'd8, 32'd0, 32'hA000_0008);
        chk("b2b_gap2", hs_cyc - prev, 4);
        chk("b2b_reads", rcnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
